// File: rtl/cheri_err_monitor_if.sv
// -----------------------------------------------------------------------------
// cheri_err_monitor_if
//
// Event stream between the CHERI error monitor and its consumer (a DPI
// reporter or a debug register block). The head of the monitor's event FIFO
// is presented first-word-fall-through with a valid/ready handshake.
//
// Signals:
//   evt_valid     monitor -> consumer  FIFO head is valid
//   evt_ready     consumer -> monitor  consumer accepts the head this cycle
//   evt_mask      monitor -> consumer  channels whose first occurrence the head records
//   evt_ts        monitor -> consumer  timestamp of the head event
//   evt_overflow  monitor -> consumer  sticky: an event was dropped on a full FIFO
//
// Modports:
//   master  the monitor (drives the event, receives ready)
//   slave   the consumer
// -----------------------------------------------------------------------------
interface cheri_err_monitor_if #(
    parameter int unsigned NumErr  = 9,
    parameter int unsigned TsWidth = 32
);
    logic                evt_valid;
    logic                evt_ready;
    logic [NumErr-1:0]   evt_mask;
    logic [TsWidth-1:0]  evt_ts;
    logic                evt_overflow;

    modport master (
        output evt_valid,
        output evt_mask,
        output evt_ts,
        output evt_overflow,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_mask,
        input  evt_ts,
        input  evt_overflow,
        output evt_ready
    );
endinterface

// File: rtl/cheri_err_monitor.sv
// -----------------------------------------------------------------------------
// cheri_err_monitor
//
// CHERI exception monitor. Watches the (LED-modulated) cheri_err lines and
//   - detects rising edges per channel,
//   - keeps sticky first-occurrence flags and saturating per-channel counters,
//   - timestamps each first occurrence with a free-running counter,
//   - queues first-occurrence events in a small FIFO drained over evt_if.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   err_i        raw error lines (level, may toggle)
//   clear_i      synchronous clear of flags, counters, overflow and FIFO
//   errored_o    sticky "channel has errored" flags
//   count_o      per-channel rising-edge counts, channel e at [e*CntWidth +: CntWidth]
//   any_err_o    OR of errored_o
//   evt_if       event stream (master side): valid/ready, mask, ts, overflow
//
// Parameters:
//   NumErr     number of error channels
//   CntWidth   width of each saturating occurrence counter
//   TsWidth    width of the free-running timestamp
//   FifoDepth  event FIFO entries, power of two, >= 2
// -----------------------------------------------------------------------------
module cheri_err_monitor #(
    parameter int unsigned NumErr    = 9,
    parameter int unsigned CntWidth  = 16,
    parameter int unsigned TsWidth   = 32,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumErr-1:0]            err_i,
    input  logic                         clear_i,
    output logic [NumErr-1:0]            errored_o,
    output logic [NumErr*CntWidth-1:0]   count_o,
    output logic                         any_err_o,
    cheri_err_monitor_if.master          evt_if
);

    localparam int unsigned AddrW = $clog2(FifoDepth);
    // One extra pointer bit tells a full FIFO from an empty one.
    localparam int unsigned PtrW  = AddrW + 1;

    typedef struct packed {
        logic [NumErr-1:0]  mask;
        logic [TsWidth-1:0] ts;
    } evt_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TsWidth-1:0]  ts_q, ts_d;
    logic [NumErr-1:0]   err_q;
    logic [NumErr-1:0]   errored_q, errored_d;
    logic [CntWidth-1:0] cnt_q [NumErr];
    logic [CntWidth-1:0] cnt_d [NumErr];
    logic                ovf_q, ovf_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    evt_t                mem_q [FifoDepth];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [NumErr-1:0] rise;
    logic [NumErr-1:0] first;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push_req;
    logic              push;
    logic              mem_we;
    logic [AddrW-1:0]  wr_addr;
    logic [AddrW-1:0]  rd_addr;
    evt_t              head;

    assign wr_addr    = wr_ptr_q[AddrW-1:0];
    assign rd_addr    = rd_ptr_q[AddrW-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                        (wr_addr == rd_addr);

    // err_q resets to 0, so a line already high at reset release is a rise.
    assign rise     = err_i & ~err_q;
    assign first    = rise & ~errored_q;
    assign pop      = !fifo_empty && evt_if.evt_ready;
    assign push_req = |first;
    // A full FIFO still accepts the push when the head leaves the same cycle.
    assign push     = push_req && (!fifo_full || pop);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned; an unassigned path would infer a latch.
        ts_d      = ts_q + TsWidth'(1);
        errored_d = errored_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_we    = 1'b0;

        if (clear_i) begin
            // Clear wins over every update in its cycle; the timestamp keeps
            // running and err_q still samples err_i.
            errored_d = '0;
            ovf_d     = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            for (int e = 0; e < int'(NumErr); e++) begin
                cnt_d[e] = '0;
            end
        end else begin
            for (int e = 0; e < int'(NumErr); e++) begin
                if (rise[e] && (cnt_q[e] != {CntWidth{1'b1}})) begin
                    cnt_d[e] = cnt_q[e] + CntWidth'(1);
                end
            end

            // Flags and counters update even when the event itself is dropped.
            errored_d = errored_q | first;

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
                mem_we   = 1'b1;
            end else if (push_req) begin
                ovf_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst_ni) begin
            ts_q      <= '0;
            err_q     <= '0;
            errored_q <= '0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int e = 0; e < int'(NumErr); e++) begin
                cnt_q[e] <= '0;
            end
        end else begin
            ts_q      <= ts_d;
            err_q     <= err_i;
            errored_q <= errored_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    // NOTE: the FIFO storage has no reset; it is only ever read through the
    // valid-gated head below, so stale contents never reach an output and
    // the array can map onto plain flops or distributed RAM.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_addr] <= '{mask: first, ts: ts_q};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign head = mem_q[rd_addr];

    assign errored_o = errored_q;
    assign any_err_o = |errored_q;

    always_comb begin
        count_o = '0;
        for (int e = 0; e < int'(NumErr); e++) begin
            count_o[e*CntWidth +: CntWidth] = cnt_q[e];
        end
    end

    // Head fields read as zero while empty so reset and clear show all-zero.
    assign evt_if.evt_valid    = !fifo_empty;
    assign evt_if.evt_mask     = fifo_empty ? '0 : head.mask;
    assign evt_if.evt_ts       = fifo_empty ? '0 : head.ts;
    assign evt_if.evt_overflow = ovf_q;

endmodule
